// File: rtl/rooth_bus_arb_pkg.sv
// Shared definitions for the rooth data-side bus arbiter: requester indices,
// FSM state encoding and the grant index width.
package rooth_bus_arb_pkg;

    localparam int ARB_JTAG = 0;
    localparam int ARB_CORE = 1;
    localparam int ARB_AUX  = 2;

    localparam int IDX_W = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational fixed-priority selector: starved candidates first, then the
// lowest-index candidate. Returns a one-hot pick plus its index.
module arb_prio_sel
    import rooth_bus_arb_pkg::*;
#(
    parameter int NUM_M = 3
) (
    input  logic [NUM_M-1:0] cand,
    input  logic [NUM_M-1:0] starved,
    output logic [NUM_M-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [NUM_M-1:0] starved_cand;
    logic [NUM_M-1:0] pool;

    assign starved_cand = cand & starved;
    assign pool         = (|starved_cand) ? starved_cand : cand;
    assign found        = |cand;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (pool[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rooth_bus_arb.sv
// Registered multi-master arbiter for the data-side bus: fixed priority with
// burst limiting, lock-based ownership, starvation aging and core stall.
module rooth_bus_arb
    import rooth_bus_arb_pkg::*;
#(
    parameter int NUM_M        = 3,
    parameter int CORE_IDX     = ARB_CORE,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_M-1:0] req_i,
    input  logic [NUM_M-1:0] lock_i,
    output logic [NUM_M-1:0] grant_o,
    output logic [IDX_W-1:0] grant_id_o,
    output logic             grant_vld_o,
    output logic             hold_o,
    output logic [NUM_M-1:0] starve_o
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [WAIT_W-1:0]  WAIT_SAT   = WAIT_W'(STARVE_LIMIT);

    arb_state_e         state_q, state_nxt;
    logic [NUM_M-1:0]   grant_q, grant_nxt;
    logic [IDX_W-1:0]   owner_q, owner_nxt;
    logic [BURST_W-1:0] burst_q, burst_nxt;
    logic [WAIT_W-1:0]  wait_cnt [NUM_M];

    logic [NUM_M-1:0]   others;
    logic [NUM_M-1:0]   cand;
    logic [NUM_M-1:0]   sel_onehot;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               new_grant;

    assign others = req_i & ~grant_q;

    arb_prio_sel #(
        .NUM_M (NUM_M)
    ) u_sel (
        .cand    (cand),
        .starved (starve_o),
        .onehot  (sel_onehot),
        .idx     (sel_idx),
        .found   (sel_found)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        owner_nxt = owner_q;
        burst_nxt = burst_q;
        cand      = '0;
        new_grant = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                cand      = req_i;
                new_grant = sel_found;
            end
            ARB_OWN: begin
                if (!req_i[owner_q]) begin
                    // Lock never blocks release; hand straight over if anyone waits.
                    cand = others;
                    if (sel_found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = ARB_IDLE;
                        grant_nxt = '0;
                        owner_nxt = '0;
                        burst_nxt = '0;
                    end
                end else if (lock_i[owner_q] || (burst_q < BURST_LAST)) begin
                    if (burst_q != BURST_LAST) begin
                        burst_nxt = burst_q + 1'b1;
                    end
                end else if (|others) begin
                    cand      = others;
                    new_grant = 1'b1;
                end else begin
                    burst_nxt = '0;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase

        if (new_grant) begin
            state_nxt = ARB_OWN;
            grant_nxt = sel_onehot;
            owner_nxt = sel_idx;
            burst_nxt = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            owner_q <= owner_nxt;
            burst_q <= burst_nxt;
        end
    end

    // NOTE: the wait counters are a tiny register array, not RAM, so they are
    // reset explicitly; a starve flag must never come out of reset set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_M; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                if (!req_i[i] || grant_q[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WAIT_SAT) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        starve_o = '0;
        for (int i = 0; i < NUM_M; i++) begin
            starve_o[i] = (wait_cnt[i] == WAIT_SAT);
        end
    end

    assign grant_o     = grant_q;
    assign grant_id_o  = owner_q;
    assign grant_vld_o = |grant_q;
    assign hold_o      = req_i[CORE_IDX] & ~grant_q[CORE_IDX];

endmodule

// File: tb/tb_rooth_bus_arb.sv
// Directed self-checking bench for rooth_bus_arb: reset, handover, burst
// alternation, lock with starvation, aux aging and mid-burst reset.
module tb_rooth_bus_arb;
    import rooth_bus_arb_pkg::*;

    localparam int NUM_M = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NUM_M-1:0] req_i;
    logic [NUM_M-1:0] lock_i;
    logic [NUM_M-1:0] grant_o;
    logic [IDX_W-1:0] grant_id_o;
    logic             grant_vld_o;
    logic             hold_o;
    logic [NUM_M-1:0] starve_o;

    int n_cmp = 0;
    int n_err = 0;

    rooth_bus_arb #(
        .NUM_M        (NUM_M),
        .CORE_IDX     (ARB_CORE),
        .MAX_BURST    (8),
        .STARVE_LIMIT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .lock_i      (lock_i),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o),
        .grant_vld_o (grant_vld_o),
        .hold_o      (hold_o),
        .starve_o    (starve_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and land 1 time unit after the last one.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_i  = '0;
        lock_i = '0;
        step(2);

        // Reset state
        check("rst_grant", grant_o, 3'b000);
        check("rst_id", grant_id_o, 2'd0);
        check("rst_vld", grant_vld_o, 1'b0);
        check("rst_starve", starve_o, 3'b000);
        req_i = 3'b010;
        #1;
        check("rst_hold", hold_o, 1'b1);
        req_i = 3'b000;
        rst_n = 1'b1;

        // Single core request: one-cycle grant latency, hold only while waiting
        step();
        req_i = 3'b010;
        #1;
        check("core_wait_hold", hold_o, 1'b1);
        check("core_wait_grant", grant_o, 3'b000);
        step();
        check("core_grant", grant_o, 3'b010);
        check("core_id", grant_id_o, 2'd1);
        check("core_vld", grant_vld_o, 1'b1);
        check("core_hold_off", hold_o, 1'b0);
        req_i = 3'b000;
        step();
        check("core_release", grant_o, 3'b000);
        check("core_release_vld", grant_vld_o, 1'b0);

        // All three request: JTAG first, then direct handover to the core
        req_i = 3'b111;
        step();
        check("all_jtag", grant_o, 3'b001);
        check("all_jtag_id", grant_id_o, 2'd0);
        check("all_hold", hold_o, 1'b1);
        step();
        check("all_jtag_c2", grant_o, 3'b001);
        step();
        check("all_jtag_c3", grant_o, 3'b001);
        req_i = 3'b110;
        step();
        check("handover_core", grant_o, 3'b010);
        check("handover_vld", grant_vld_o, 1'b1);
        req_i = 3'b000;
        step();
        check("handover_idle", grant_o, 3'b000);

        // JTAG and core alternate in 8-cycle bursts
        req_i = 3'b011;
        step();
        for (int k = 0; k < 8; k++) begin
            check("burst_jtag", grant_o, 3'b001);
            if (k == 0) check("burst_jtag_hold", hold_o, 1'b1);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            check("burst_core", grant_o, 3'b010);
            if (k == 0) check("burst_core_hold", hold_o, 1'b0);
            step();
        end
        check("burst_jtag_again", grant_o, 3'b001);
        req_i = 3'b000;
        step();
        check("burst_idle", grant_o, 3'b000);

        // Locked JTAG holds 30 cycles; core starves after 15 wait edges
        req_i  = 3'b001;
        lock_i = 3'b001;
        step();
        check("lock_grant", grant_o, 3'b001);
        req_i = 3'b011;
        for (int i = 1; i < 30; i++) begin
            step();
            check("lock_keep", grant_o, 3'b001);
            if (i == 14) check("lock_starve_pre", starve_o, 3'b000);
            if (i == 15) check("lock_starve_set", starve_o, 3'b010);
        end
        check("lock_hold", hold_o, 1'b1);
        req_i  = 3'b010;
        lock_i = 3'b000;
        step();
        check("unlock_core", grant_o, 3'b010);
        check("unlock_starve_held", starve_o, 3'b010);
        step();
        check("unlock_starve_clr", starve_o, 3'b000);
        req_i = 3'b000;
        step();
        check("unlock_idle", grant_o, 3'b000);

        // Aux ages while JTAG/core alternate, then wins the next re-arbitration
        req_i = 3'b011;
        step();
        check("age_jtag", grant_o, 3'b001);
        req_i = 3'b111;
        step(14);
        check("age_core", grant_o, 3'b010);
        check("age_starve_pre", starve_o, 3'b000);
        step();
        check("age_core_last", grant_o, 3'b010);
        check("age_starve_set", starve_o, 3'b100);
        step();
        check("age_aux_win", grant_o, 3'b100);
        check("age_aux_id", grant_id_o, 2'd2);
        step();
        check("age_aux_keep", grant_o, 3'b100);
        check("age_starve_clr", starve_o, 3'b000);

        // Asynchronous reset mid-burst, then a clean restart
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", grant_o, 3'b000);
        check("mid_rst_id", grant_id_o, 2'd0);
        check("mid_rst_vld", grant_vld_o, 1'b0);
        check("mid_rst_starve", starve_o, 3'b000);
        check("mid_rst_hold", hold_o, 1'b1);
        req_i = 3'b010;
        rst_n = 1'b1;
        step();
        check("post_rst_grant", grant_o, 3'b010);
        check("post_rst_id", grant_id_o, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
